// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the iterative shift unit
package shift_pkg;

    localparam int WIDTH = 5;
    localparam int AMT_W = 2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_iter_if.sv
// rtl/shift_iter_if.sv - start/ready/done request and result bundle for shift_iter
interface shift_iter_if #(
    parameter int WIDTH = 5,
    parameter int AMT_W = 2
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [AMT_W-1:0] bshift;
    logic             dir;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             carry;
    logic             zero;

    modport master (
        output start, A, bshift, dir,
        input  ready, done, Result, carry, zero
    );

    modport slave (
        input  start, A, bshift, dir,
        output ready, done, Result, carry, zero
    );
endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-position logical shift, combinational
module shift_step #(
    parameter int W = 5
) (
    input  logic [W-1:0] work_i,
    input  logic         d_i,
    output logic [W-1:0] work_o,
    output logic         out_bit_o
);
    import shift_pkg::*;

    always_comb begin
        work_o    = '0;
        out_bit_o = 1'b0;
        if (d_i == DIR_LEFT) begin
            work_o    = {work_i[W-2:0], 1'b0};
            out_bit_o = work_i[W-1];
        end else begin
            work_o    = {1'b0, work_i[W-1:1]};
            out_bit_o = work_i[0];
        end
    end
endmodule

// File: rtl/shift_iter.sv
// rtl/shift_iter.sv - sequenced logical shifter, one bit position per clock
module shift_iter #(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int AMT_W = shift_pkg::AMT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    shift_iter_if.slave bus
);
    import shift_pkg::*;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [AMT_W-1:0] cnt_q;
    logic             dir_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;

    logic [WIDTH-1:0] work_d;
    logic             out_bit_d;

    shift_step #(.W(WIDTH)) u_step (
        .work_i    (work_q),
        .d_i       (dir_q),
        .work_o    (work_d),
        .out_bit_o (out_bit_d)
    );

    // Result/carry/zero only update on entry to DONE so they stay stable while shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_LEFT;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        work_q <= bus.A;
                        cnt_q  <= bus.bshift;
                        dir_q  <= bus.dir;
                        if (bus.bshift != '0) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q  <= DONE;
                            result_q <= bus.A;
                            carry_q  <= 1'b0;
                            zero_q   <= (bus.A == '0);
                        end
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_q  <= DONE;
                        result_q <= work_d;
                        carry_q  <= out_bit_d;
                        zero_q   <= (work_d == '0);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.Result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_shift_iter.sv
// tb/tb_shift_iter.sv - directed self-checking bench for shift_iter
module tb_shift_iter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    shift_iter_if #(.WIDTH(5), .AMT_W(2)) bus ();

    shift_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launches one op at the next edge and checks latency and results at the done cycle.
    // With hold=1 a second start (A=11111) is kept asserted through SHIFT/DONE and must be ignored.
    task automatic run_op(input string tag, input logic [4:0] a, input int n, input logic d,
                          input logic [4:0] prev_res, input logic [4:0] exp_res,
                          input logic exp_c, input logic exp_z, input logic hold);
        int k;
        bus.start  = 1'b1;
        bus.A      = a;
        bus.bshift = 2'(n);
        bus.dir    = d;
        @(posedge clk);
        #1;
        if (hold) begin
            bus.A      = 5'b11111;
            bus.bshift = 2'd1;
            bus.dir    = 1'b0;
        end else begin
            bus.start  = 1'b0;
            bus.A      = ~a;
            bus.bshift = 2'(3 - n);
            bus.dir    = ~d;
        end
        @(negedge clk);
        if (n > 0) begin
            check({tag, "_busy_ready"}, 32'(bus.ready), 32'd0);
            check({tag, "_hold_res"}, 32'(bus.Result), 32'(prev_res));
        end
        k = 0;
        while (!bus.done && k < 8) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, n);
        check({tag, "_res"}, 32'(bus.Result), 32'(exp_res));
        check({tag, "_carry"}, 32'(bus.carry), 32'(exp_c));
        check({tag, "_zero"}, 32'(bus.zero), 32'(exp_z));
        check({tag, "_done_ready"}, 32'(bus.ready), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, "_after_done"}, 32'(bus.done), 32'd0);
        check({tag, "_after_ready"}, 32'(bus.ready), 32'd1);
        check({tag, "_after_res"}, 32'(bus.Result), 32'(exp_res));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.A      = 5'b0;
        bus.bshift = 2'd0;
        bus.dir    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_res", 32'(bus.Result), 32'd0);
        check("rst_carry", 32'(bus.carry), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd1);
        rst_n  = 1'b1;
        bus.A  = 5'b10101;
        bus.bshift = 2'd3;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_res", 32'(bus.Result), 32'd0);
        check("idle_zero", 32'(bus.zero), 32'd1);

        run_op("l2", 5'b10110, 2, 1'b0, 5'b00000, 5'b11000, 1'b0, 1'b0, 1'b0);
        run_op("r3", 5'b10110, 3, 1'b1, 5'b11000, 5'b00010, 1'b1, 1'b0, 1'b0);
        run_op("n0", 5'b10110, 0, 1'b0, 5'b00010, 5'b10110, 1'b0, 1'b0, 1'b0);
        run_op("r1", 5'b00001, 1, 1'b1, 5'b10110, 5'b00000, 1'b1, 1'b1, 1'b1);
        run_op("l1", 5'b11111, 1, 1'b0, 5'b00000, 5'b11110, 1'b1, 1'b0, 1'b0);

        bus.start  = 1'b1;
        bus.A      = 5'b11111;
        bus.bshift = 2'd3;
        bus.dir    = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.ready), 32'd1);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_res", 32'(bus.Result), 32'd0);
        check("arst_carry", 32'(bus.carry), 32'd0);
        check("arst_zero", 32'(bus.zero), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(bus.done), 32'd0);
            check("post_rst_ready", 32'(bus.ready), 32'd1);
        end
        check("post_rst_res", 32'(bus.Result), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_iter.md
# shift_iter

Iterative shift unit for the 5-bit ALU datapath. It performs the same logical left/right shift by 0–3 positions as the combinational shifter, but moves one bit position per clock. It reports the last bit shifted out and a zero flag, and uses a start/ready/done handshake. It sits beside the ALU as the sequenced shift path for the multi-cycle control unit, which needs per-step carry-out and a completion strobe.

## Interface
- WIDTH, 5, operand/result width
- AMT_W, 2, shift-amount width (max shift 2^AMT_W−1 = 3)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when ready=1
- A  in  WIDTH  operand, captured with start
- bshift  in  AMT_W  shift amount n, captured with start
- dir  in  1  0 = left, 1 = right; captured with start
- ready  out  1  high in IDLE only
- done  out  1  one-cycle completion pulse
- Result  out  WIDTH  shifted value, registered
- carry  out  1  last bit shifted out; 0 when n=0
- zero  out  1  Result==0, registered with Result

## Operation
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ready=1, done=0, Result=0, carry=0, zero=1; working register and counter 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge loads work=A, cnt=bshift, d=dir.
  - Next state is SHIFT if bshift≠0, else DONE with carry_next=0.
- SHIFT, each cycle:
  - Left: work←{work[W−2:0],0}, out-bit = work[W−1].
  - Right: work←{0,work[W−1:1]}, out-bit = work[0].
  - cnt←cnt−1.
  - When cnt==1 before the decrement, go to DONE.
- Entering DONE: Result←final work, carry←last out-bit, zero←(final work==0).
- DONE: done=1, ready=0. Next state is unconditionally IDLE.
- Logical shifts only; vacated bits are 0. No rotate, no sign fill.
- Result, carry and zero hold their values from DONE until the next completion. They do not change during SHIFT.
- start while ready=0 is ignored; it is not queued.
- start during the DONE cycle is ignored. Earliest accepted restart is the cycle after done.
- A, bshift and dir changing after capture have no effect on the operation in flight.
- Reset mid-operation: immediate return to reset values. No done pulse is produced for the aborted operation.

## Timing
- Let E0 be the edge at which start is accepted, and n = bshift.
- done is high for exactly the one cycle following edge E0+n.
  - n=0: done in the cycle right after E0.
  - n=3: done in the cycle after E3.
- Back-to-back throughput is one operation per n+2 cycles.
- Outputs are registered except ready and done, which are decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package shift_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - WIDTH and AMT_W defaults
  - direction constants DIR_LEFT=0, DIR_RIGHT=1
- Optional sub-module shift_step: a combinational single-position shift.
  - Inputs: work, d.
  - Outputs: next work, out-bit.
- FSM, counter and output registers stay in shift_iter.

## Test plan
- Reset, then idle: ready=1, done=0, Result=0, carry=0, zero=1; no change without start.
- A=10110, n=2, dir=0 -> done at E0+2, Result=11000, carry=0, zero=0.
- A=10110, n=3, dir=1 -> done at E0+3, Result=00010, carry=1, zero=0.
- A=10110, n=0 -> done in the cycle after E0, Result=10110, carry=0, ready low only during DONE.
- A=00001, n=1, dir=1 -> Result=00000, carry=1, zero=1. A second start during SHIFT/DONE with A=11111 is ignored; the next op with A=11111, n=1, dir=0 gives Result=11110, carry=1.
- Start with A=11111, n=3; deassert rst_n one cycle after E0 -> outputs return to reset values at once, no done pulse, ready=1 after reset release.
